// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_pkg
//  Purpose  : Shared types and default widths for the sqrt core arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package sqrt_pkg;

  localparam int SQRT_N_DEFAULT    = 16;
  localparam int SQRT_NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } sqrt_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first set request at or after
//             the pointer, wrapping to the lowest set request otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import sqrt_pkg::*;
#(
  parameter int NREQ = SQRT_NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic           w_hit_hi;
  logic           w_hit_lo;
  logic [IDW-1:0] w_idx_hi;
  logic [IDW-1:0] w_idx_lo;

  // Two searches: lowest request at/after ptr, and lowest request overall (the wrap case)
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    gnt      = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j] && !w_hit_lo) begin
        w_hit_lo = 1'b1;
        w_idx_lo = IDW'(j);
      end
      if (req[j] && (j >= int'(ptr)) && !w_hit_hi) begin
        w_hit_hi = 1'b1;
        w_idx_hi = IDW'(j);
      end
    end
    any     = w_hit_lo;
    gnt_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
    if (w_hit_lo) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_arbiter
//  Purpose  : Shares one sequential sqrt core between NREQ requesters with a
//             round-robin grant; one operation in flight, result returned to
//             the granted requester only.
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter  int N    = SQRT_N_DEFAULT,
  parameter  int NREQ = SQRT_NREQ_DEFAULT,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_vld,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*N-1:0] req_num,
  output logic [N/2-1:0]    res,
  output logic [NREQ-1:0]   res_vld,
  input  logic [NREQ-1:0]   res_rdy,
  output logic [N-1:0]      core_num,
  output logic              core_vld,
  input  logic              core_rdy,
  input  logic [N/2-1:0]    core_res,
  input  logic              core_res_vld,
  output logic              core_res_rdy,
  output logic              busy,
  output logic [IDW-1:0]    gnt_id
);

  sqrt_arb_state_t state_q, state_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]    opnd_q, opnd_d;
  logic [N/2-1:0]  res_q, res_d;
  logic [NREQ-1:0] req_rdy_q, req_rdy_d;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req_vld),
    .ptr     (ptr_q),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // State, held operand/result, grant index and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      opnd_q    <= '0;
      res_q     <= '0;
      req_rdy_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      req_rdy_q <= req_rdy_d;
    end
  end

  // Next state plus the register updates tied to each transition
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    req_rdy_d = '0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          state_d   = ISSUE;
          gnt_id_d  = w_gnt_idx;
          req_rdy_d = w_gnt;
          for (int k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) begin
              opnd_d = req_num[k*N +: N];
            end
          end
        end
      end
      ISSUE: begin
        if (core_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (core_res_vld) begin
          res_d   = core_res;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        // The pointer moves only once the result is taken, so a stalled
        // requester keeps its place in the rotation.
        if (res_rdy[gnt_id_q]) begin
          ptr_d   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    req_rdy      = req_rdy_q;
    core_vld     = (state_q == ISSUE);
    core_num     = opnd_q;
    core_res_rdy = (state_q == WAIT);
    busy         = (state_q != IDLE);
    res          = res_q;
    gnt_id       = gnt_id_q;
    res_vld      = '0;
    if (state_q == DELIVER) begin
      res_vld[gnt_id_q] = 1'b1;
    end
  end

endmodule
`default_nettype wire
